duck_spawn_ctrl: RTL

Consumer of the game's pseudo-random word stream. On each spawn request it pulls fresh random words from the LFSR generator through a one-cycle `rand_en` pulse per draw. From those words it derives a random launch delay, a bounded horizontal start position (rejection sampling), a vertical start position and a flight direction. It then offers the resulting duck spawn descriptor to the game FSM over a valid/ready handshake.

---
 rtl/duck_spawn_ctrl_if.sv | 35 +++
 rtl/duck_spawn_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/duck_spawn_ctrl_if.sv
// ============================================================================
// duck_spawn_ctrl_if
// Random-stream and spawn-descriptor signals between the spawn controller,
// the LFSR generator and the game FSM.
// Rev 1.0
// ============================================================================
`default_nettype none

interface duck_spawn_ctrl_if #(
    parameter int unsigned RAND_WIDTH = 16
);
    logic [RAND_WIDTH-1:0] random;
    logic                  rand_en;
    logic                  spawn_req;
    logic                  spawn_valid;
    logic                  spawn_ready;
    logic [10:0]           spawn_x;
    logic [9:0]            spawn_y;
    logic                  spawn_dir;
    logic                  busy;

    // master: the spawn controller
    modport master (
        input  random, spawn_req, spawn_ready,
        output rand_en, spawn_valid, spawn_x, spawn_y, spawn_dir, busy
    );

    // slave: generator + game FSM side
    modport slave (
        output random, spawn_req, spawn_ready,
        input  rand_en, spawn_valid, spawn_x, spawn_y, spawn_dir, busy
    );
endinterface

`default_nettype wire

// File: rtl/duck_spawn_ctrl.sv
// ============================================================================
// duck_spawn_ctrl
// Draws random words to build a delayed duck spawn descriptor (x, y, dir)
// and offers it over a valid/ready handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module duck_spawn_ctrl #(
    parameter int unsigned RAND_WIDTH  = 16,
    parameter int unsigned X_MIN       = 16,
    parameter int unsigned X_SPAN      = 736,
    parameter int unsigned Y_MIN       = 64,
    parameter int unsigned Y_SPAN      = 256,
    parameter int unsigned DELAY_MIN   = 25_000_000,
    parameter int unsigned DELAY_SHIFT = 16,
    parameter int unsigned MAX_TRIES   = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    duck_spawn_ctrl_if.master sp
);

    localparam int unsigned           c_TRY_W      = $clog2(MAX_TRIES + 1);
    localparam logic [10:0]           c_X_MIN      = 11'(X_MIN);
    localparam logic [11:0]           c_X_SPAN     = 12'(X_SPAN);
    localparam logic [10:0]           c_X_FALLBACK = 11'(X_MIN + X_SPAN / 2);
    localparam logic [9:0]            c_Y_MIN      = 10'(Y_MIN);
    localparam logic [9:0]            c_Y_MASK     = 10'(Y_SPAN - 1);
    localparam logic [31:0]           c_DELAY_MIN  = 32'(DELAY_MIN);
    localparam logic [c_TRY_W-1:0]    c_MAX_TRIES  = c_TRY_W'(MAX_TRIES);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_D_DRAW = 4'd1,
        S_D_USE  = 4'd2,
        S_WAIT   = 4'd3,
        S_X_DRAW = 4'd4,
        S_X_USE  = 4'd5,
        S_Y_DRAW = 4'd6,
        S_Y_USE  = 4'd7,
        S_VALID  = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_delay;
    logic [c_TRY_W-1:0]   r_tries;
    logic [10:0]          r_x;
    logic [9:0]           r_y;
    logic                 r_dir;

    logic [RAND_WIDTH-1:0] w_r;
    logic [31:0]           w_delay_load;
    logic                  w_x_ok;
    logic [10:0]           w_x_sum;
    logic [9:0]            w_y_sum;
    logic [c_TRY_W-1:0]    w_tries_inc;
    logic                  w_more_tries;
    logic                  w_rand_en;
    logic                  w_valid;
    logic                  w_busy;
    logic                  w_unused_bits;

    assign w_r           = sp.random;
    assign w_unused_bits = ^w_r;

    // Output sums wrap at output width, identical to a full-width sum truncated
    assign w_delay_load = c_DELAY_MIN + (32'(w_r[7:0]) << DELAY_SHIFT);
    assign w_x_ok       = ({1'b0, w_r[10:0]} < c_X_SPAN);
    assign w_x_sum      = c_X_MIN + w_r[10:0];
    assign w_y_sum      = c_Y_MIN + (w_r[9:0] & c_Y_MASK);
    assign w_tries_inc  = r_tries + c_TRY_W'(1);
    assign w_more_tries = (w_tries_inc < c_MAX_TRIES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rand_en   = 1'b0;
        w_valid     = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (sp.spawn_req) w_state_nxt = S_D_DRAW;
            end
            S_D_DRAW: begin
                w_rand_en   = 1'b1;
                w_state_nxt = S_D_USE;
            end
            S_D_USE:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (r_delay == 32'd0) w_state_nxt = S_X_DRAW;
            end
            S_X_DRAW: begin
                w_rand_en   = 1'b1;
                w_state_nxt = S_X_USE;
            end
            S_X_USE: begin
                if (w_x_ok || !w_more_tries) w_state_nxt = S_Y_DRAW;
                else                         w_state_nxt = S_X_DRAW;
            end
            S_Y_DRAW: begin
                w_rand_en   = 1'b1;
                w_state_nxt = S_Y_USE;
            end
            S_Y_USE:  w_state_nxt = S_VALID;
            S_VALID: begin
                w_valid = 1'b1;
                if (sp.spawn_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delay <= 32'd0;
            r_tries <= '0;
            r_x     <= c_X_MIN;
            r_y     <= c_Y_MIN;
            r_dir   <= 1'b0;
        end else begin
            case (r_state)
                S_D_USE: r_delay <= w_delay_load;
                S_WAIT: begin
                    // Try counter is cleared on the way out to the first x draw
                    if (r_delay != 32'd0) r_delay <= r_delay - 32'd1;
                    else                  r_tries <= '0;
                end
                S_X_USE: begin
                    if (w_x_ok) begin
                        r_x <= w_x_sum;
                    end else begin
                        r_tries <= w_tries_inc;
                        if (!w_more_tries) r_x <= c_X_FALLBACK;
                    end
                end
                S_Y_USE: begin
                    r_y   <= w_y_sum;
                    r_dir <= w_r[15];
                end
                default: ;
            endcase
        end
    end

    assign sp.rand_en     = w_rand_en;
    assign sp.spawn_valid = w_valid;
    assign sp.busy        = w_busy;
    assign sp.spawn_x     = r_x;
    assign sp.spawn_y     = r_y;
    assign sp.spawn_dir   = r_dir;

endmodule

`default_nettype wire
